// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the pipelined carry adder:
//   op_e       - operation select (OP_ADD / OP_SUB), decoded from the 'sub' pin
//   seg_width  - bits per carry segment, WIDTH / STAGES
// ----------------------------------------------------------------------------
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int unsigned seg_width(input int unsigned width,
                                              input int unsigned stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_segment.sv
// ----------------------------------------------------------------------------
// adder_segment
// Purely combinational SEG-bit adder slice with carry in/out.
// Ports:
//   a, b  [SEG-1:0]  operand slices
//   cin              carry into the slice
//   sum   [SEG-1:0]  slice sum
//   cout             carry out of the slice MSB
// ----------------------------------------------------------------------------
module adder_segment #(
    parameter int unsigned SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    // Widen by one bit so the carry out falls into the top bit of the result.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

endmodule

// File: rtl/pipelined_carry_adder.sv
// ----------------------------------------------------------------------------
// pipelined_carry_adder
// WIDTH-bit add/subtract unit split into STAGES carry segments, one pipeline
// register per segment, with a valid/ready handshake on both sides.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  input handshake (in_ready = pipeline advance)
//   a, b   [WIDTH-1:0]  operands
//   cin                 carry-in, ignored when subtracting
//   sub                 0 = add, 1 = subtract (a + ~b + 1)
//   out_valid, out_ready output handshake
//   sum    [WIDTH-1:0]  result, modulo 2^WIDTH
//   cout                carry out of the MSB (inverted borrow when subtracting)
//   ovf                 two's-complement signed overflow
// ----------------------------------------------------------------------------
module pipelined_carry_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned SEG  = seg_width(WIDTH, STAGES);
    localparam int unsigned MSB  = WIDTH - 1;
    localparam int unsigned LAST = STAGES - 1;

    if (WIDTH % STAGES != 0) begin : g_bad_params
        $error("pipelined_carry_adder: WIDTH must be a multiple of STAGES");
    end

    // Operand conditioning: subtraction becomes a + ~b + 1.
    op_e              op;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic             adv;

    assign op    = op_e'(sub);
    assign b_eff = (op == OP_SUB) ? ~b : b;
    assign c_eff = (op == OP_SUB) ? 1'b1 : cin;

    // A single advance strobe moves every stage at once, so a stall anywhere
    // freezes the whole skewed pipeline and keeps the segments aligned.
    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    // Stage inputs (from the ports for stage 0, from registers otherwise).
    logic             v_in     [STAGES];
    logic [WIDTH-1:0] a_in     [STAGES];
    logic [WIDTH-1:0] b_in     [STAGES];
    logic [WIDTH-1:0] s_in     [STAGES];
    logic             c_in     [STAGES];
    logic [SEG-1:0]   seg_sum  [STAGES];
    logic             seg_co   [STAGES];
    logic [WIDTH-1:0] s_next   [STAGES];

    // Stage registers.
    logic             vld_q    [STAGES];
    logic [WIDTH-1:0] a_q      [STAGES];
    logic [WIDTH-1:0] b_q      [STAGES];
    logic [WIDTH-1:0] s_q      [STAGES];
    logic             c_q      [STAGES];
    logic             ovf_q;
    logic             ovf_next;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign v_in[k] = in_valid;
            assign a_in[k] = a;
            assign b_in[k] = b_eff;
            assign s_in[k] = '0;
            assign c_in[k] = c_eff;
        end else begin : g_next
            assign v_in[k] = vld_q[k-1];
            assign a_in[k] = a_q[k-1];
            assign b_in[k] = b_q[k-1];
            assign s_in[k] = s_q[k-1];
            assign c_in[k] = c_q[k-1];
        end

        adder_segment #(
            .SEG (SEG)
        ) u_seg (
            .a    (a_in[k][k*SEG +: SEG]),
            .b    (b_in[k][k*SEG +: SEG]),
            .cin  (c_in[k]),
            .sum  (seg_sum[k]),
            .cout (seg_co[k])
        );

        // Sum bits above the segments already computed are always zero, so
        // OR-ing the new slice in place is enough to assemble the result.
        assign s_next[k] = s_in[k] | (WIDTH'(seg_sum[k]) << (k * SEG));
    end

    // Overflow needs the operand sign bits and the final sum sign bit, all of
    // which are available together only in the last stage.
    assign ovf_next = (a_in[LAST][MSB] == b_in[LAST][MSB]) &
                      (s_next[LAST][MSB] != a_in[LAST][MSB]);

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value; blocking here would let data
    // ripple through several stages in a single clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= v_in[k];
                a_q[k]   <= a_in[k];
                b_q[k]   <= b_in[k];
                s_q[k]   <= s_next[k];
                c_q[k]   <= seg_co[k];
            end
            ovf_q <= ovf_next;
        end
    end

    assign out_valid = vld_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;

endmodule

// File: doc/pipelined_carry_adder.md
PIPELINED_CARRY_ADDER -- requirements
Module: pipelined_carry_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter STAGES, default 4, number of carry segments and pipeline registers; WIDTH SHALL be an integer multiple of STAGES, so SEG = WIDTH/STAGES.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  the operand set on a, b, cin and sub is valid.
REQ-006 in_ready  output  1  the block accepts an operand set this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in; used only when sub=0.
REQ-010 sub  input  1  operation select: 0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result fields hold a valid result.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry-out of the MSB; in subtract mode this is the inverted borrow.
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Transfer rules: an input transfer occurs when in_valid and in_ready are both high; an output transfer occurs when out_valid and out_ready are both high.
REQ-017 Effective operands: add gives a + b + cin; subtract gives a + ~b + 1, and cin SHALL be ignored.
REQ-018 Segmentation: stage k (0..STAGES-1) adds operand bits [k*SEG +: SEG] using the carry registered by stage k-1; stage 0 uses the effective carry-in.
REQ-019 Skew alignment: each stage carries forward the unconsumed upper operand segments and the already-computed lower sum segments, so every result is bit-coherent.
REQ-020 Advance: the whole pipeline advances when adv = !out_valid | out_ready; in_ready SHALL equal adv.
REQ-021 Latency: exactly STAGES cycles from input transfer to out_valid when no stall occurs; throughput SHALL be one result per cycle.
REQ-022 Stall: while adv=0, every pipeline register, including sum, cout, ovf and out_valid, SHALL hold its value.
REQ-023 Bubbles: a stage with in_valid low at entry SHALL carry a valid bit of 0 and SHALL NOT produce out_valid.
REQ-024 Width rules: the sum wraps modulo 2^WIDTH; cout is bit WIDTH of the effective addition.
REQ-025 Overflow: ovf = (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB]), computed in the final stage.
REQ-026 Ordering: results SHALL leave in acceptance order, with no loss or duplication under any in_valid/out_ready pattern.
REQ-027 Concurrency: an output transfer and an input transfer in the same cycle SHALL both complete.
REQ-028 STAGES=1: the block degenerates to a single registered adder with latency 1 and the same handshake.

Reset
REQ-029 Assertion: on rst_n low, all valid bits, out_valid, sum, cout, ovf and the inter-stage carries SHALL go to 0 immediately, without waiting for clk.
REQ-030 Flush: reset mid-operation discards every in-flight result; no pre-reset result SHALL appear after release.
REQ-031 Release: in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-032 Shared package adder_pkg SHALL hold the op_e typedef (OP_ADD, OP_SUB) and the SEG derivation function.
REQ-033 Sub-module: each stage SHALL instantiate one combinational sub-module, adder_segment (SEG-bit add with carry in/out); stage registers live in pipelined_carry_adder.
REQ-034 Parameter check: an elaboration-time check SHALL reject WIDTH % STAGES != 0.

Verification
REQ-035 WIDTH=32, STAGES=4: a=0xFFFFFFFF, b=0, cin=1, add -> sum=0x00000000, cout=1, ovf=0, out_valid exactly 4 cycles after acceptance.
REQ-036 Subtract: a=5, b=7, sub=1, cin=1 -> sum=0xFFFFFFFE, cout=0, ovf=0 (cin ignored).
REQ-037 Signed overflow: a=0x7FFFFFFF, b=1, add -> sum=0x80000000, ovf=1, cout=0; a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, ovf=1, cout=1.
REQ-038 Backpressure: 8 back-to-back operands (a=i, b=i*0x01010101), out_ready low for 3 cycles mid-stream -> in_ready low during the stall, all 8 results correct and in order, none duplicated.
REQ-039 Reset mid-operation: assert rst_n with 3 results in flight -> out_valid=0 asynchronously, and no result appears after release until new input is accepted.
REQ-040 Minimal configuration, WIDTH=4, STAGES=1: a=4'hF, b=4'h0, cin=1 -> sum=4'h0, cout=1, latency 1 cycle.
